// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one variable-latency unified memory between fetch and data stages
// Ports: clk/rst (async, active high); if_* fetch requester (req, addr, flush -> rdata, valid, stall_F_o);
// d_* data requester (req, we, addr, wdata, be -> rdata, valid, stall_M_o);
// mem_* memory side (req, we, addr, wdata, be -> rdata, ack).
module mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    input  logic                    if_flush_i,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    output logic                    if_valid_o,
    output logic                    stall_F_o,
    input  logic                    d_req_i,
    input  logic                    d_we_i,
    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] d_be_i,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,
    output logic                    d_valid_o,
    output logic                    stall_M_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_ack_i
);
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
    typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY, DONE} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic disc, done_f, grant_f, grant_d, kill;
    logic t_we;
    logic [ADDR_WIDTH-1:0] t_addr;
    logic [DATA_WIDTH-1:0] t_wdata;
    logic [DATA_WIDTH/8-1:0] t_be;
    always_comb begin
        grant_f = state == IDLE && if_req_i && !if_flush_i && (!d_req_i || cnt == LIM);
        grant_d = state == IDLE && d_req_i && !grant_f;
        // a flush landing in the ack cycle still abandons the fetch
        kill = disc | if_flush_i;
        state_nx = state;
        case (state)
            IDLE:    state_nx = grant_f ? IF_BUSY : grant_d ? D_BUSY : IDLE;
            IF_BUSY: state_nx = mem_ack_i ? (kill ? IDLE : DONE) : IF_BUSY;
            D_BUSY:  state_nx = mem_ack_i ? DONE : D_BUSY;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt        <= '0;
            disc       <= 1'b0;
            done_f     <= 1'b0;
            t_we       <= 1'b0;
            t_addr     <= '0;
            t_wdata    <= '0;
            t_be       <= '0;
            if_rdata_o <= '0;
            d_rdata_o  <= '0;
        end else begin
            if (grant_f || grant_d) begin
                t_addr  <= grant_f ? if_addr_i : d_addr_i;
                t_we    <= grant_d & d_we_i;
                t_wdata <= d_wdata_i;
                t_be    <= grant_f ? '1 : d_be_i;
                done_f  <= grant_f;
            end
            if (grant_f) cnt <= '0;
            else if (grant_d && if_req_i && cnt != LIM) cnt <= cnt + 4'd1;
            if (state == IF_BUSY) disc <= mem_ack_i ? 1'b0 : kill;
            if (state == IF_BUSY && mem_ack_i && !kill) if_rdata_o <= mem_rdata_i;
            if (state == D_BUSY && mem_ack_i && !t_we) d_rdata_o <= mem_rdata_i;
        end
    assign mem_req_o   = state == IF_BUSY || state == D_BUSY;
    assign mem_we_o    = t_we;
    assign mem_addr_o  = t_addr;
    assign mem_wdata_o = t_wdata;
    assign mem_be_o    = t_be;
    assign if_valid_o  = state == DONE && done_f;
    assign d_valid_o   = state == DONE && !done_f;
    assign stall_F_o   = if_req_i & ~if_valid_o;
    assign stall_M_o   = d_req_i & ~d_valid_o;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed check of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    localparam int LIM = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic if_req_i = 0, if_flush_i = 0, d_req_i = 0, d_we_i = 0, mem_ack_i = 0;
    logic [31:0] if_addr_i = 0, d_addr_i = 0, d_wdata_i = 0, mem_rdata_i = 0;
    logic [3:0] d_be_i = 0;
    logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
    logic if_valid_o, stall_F_o, d_valid_o, stall_M_o, mem_req_o, mem_we_o;
    logic [3:0] mem_be_o;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o), .stall_F_o(stall_F_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_be_i(d_be_i), .d_rdata_o(d_rdata_o), .d_valid_o(d_valid_o), .stall_M_o(stall_M_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i)
    );

    int checks = 0, errors = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // word-addressed backing store seen by the memory responder
    bit [31:0] mem [bit [31:0]];
    function automatic bit [31:0] rd(input bit [31:0] a);
        return mem.exists(a >> 2) ? mem[a >> 2] : 32'h0;
    endfunction

    // model: at most one outstanding transaction plus a pending completion pulse
    bit m_busy, m_who, m_we, m_disc, m_done, m_dwho;
    bit [31:0] m_addr, m_wdata, m_ifd, m_dd;
    bit [3:0] m_be;
    int m_cnt;
    int wait_n = 1, req_cyc = 0, n_if = 0, n_d = 0;
    bit rnd_mem = 0;
    bit s_ifr, s_iff, s_dr, s_dwe, s_ack, s_mreq, s_mwe;
    bit [31:0] s_ia, s_da, s_dwd, s_rd, s_maddr, s_mwd;
    bit [3:0] s_dbe, s_mbe;

    task automatic model_reset();
        m_busy = 0; m_who = 0; m_we = 0; m_disc = 0; m_done = 0; m_dwho = 0;
        m_addr = 0; m_wdata = 0; m_ifd = 0; m_dd = 0; m_be = 0; m_cnt = 0; req_cyc = 0;
    endtask

    task automatic model_edge();
        bit fw;
        if (m_done) m_done = 0;
        else if (!m_busy) begin
            fw = s_ifr && !s_iff && (!s_dr || m_cnt == LIM);
            if (fw) begin
                m_busy = 1; m_who = 0; m_addr = s_ia; m_we = 0; m_be = 4'hF; m_cnt = 0;
            end else if (s_dr) begin
                m_busy = 1; m_who = 1; m_addr = s_da; m_we = s_dwe; m_wdata = s_dwd; m_be = s_dbe;
                if (s_ifr && m_cnt < LIM) m_cnt++;
            end
        end else begin
            if (!m_who && s_iff) m_disc = 1;
            if (s_ack) begin
                m_busy = 0;
                if (!m_who) begin
                    if (!m_disc) begin m_ifd = s_rd; m_done = 1; m_dwho = 0; end
                    m_disc = 0;
                end else begin
                    if (!m_we) m_dd = s_rd;
                    m_done = 1; m_dwho = 1;
                end
            end
        end
    endtask

    task automatic tick();
        bit [31:0] w;
        #1;
        check("stall_F", stall_F_o, if_req_i && !(m_done && !m_dwho));
        check("stall_M", stall_M_o, d_req_i && !(m_done && m_dwho));
        s_ifr = if_req_i; s_iff = if_flush_i; s_ia = if_addr_i; s_dr = d_req_i; s_dwe = d_we_i;
        s_da = d_addr_i; s_dwd = d_wdata_i; s_dbe = d_be_i; s_ack = mem_ack_i; s_rd = mem_rdata_i;
        s_mreq = mem_req_o; s_mwe = mem_we_o; s_maddr = mem_addr_o; s_mwd = mem_wdata_o; s_mbe = mem_be_o;
        @(posedge clk);
        #1;
        if (s_ack && s_mreq && s_mwe) begin
            w = rd(s_maddr);
            for (int b = 0; b < 4; b++) if (s_mbe[b]) w[8*b +: 8] = s_mwd[8*b +: 8];
            mem[s_maddr >> 2] = w;
        end
        model_edge();
        check("mem_req", mem_req_o, m_busy);
        if (m_busy) begin
            check("mem_addr", mem_addr_o, m_addr);
            check("mem_we", mem_we_o, m_we);
            check("mem_be", mem_be_o, m_be);
            if (m_we) check("mem_wdata", mem_wdata_o, m_wdata);
        end
        check("if_valid", if_valid_o, m_done && !m_dwho);
        check("d_valid", d_valid_o, m_done && m_dwho);
        check("if_rdata", if_rdata_o, m_ifd);
        check("d_rdata", d_rdata_o, m_dd);
        if (if_valid_o) n_if++;
        if (d_valid_o) n_d++;
        if (mem_req_o) begin
            req_cyc++;
            mem_ack_i = rnd_mem ? $urandom_range(0, 2) == 0 : req_cyc > wait_n;
            mem_rdata_i = rd(mem_addr_o);
        end else begin
            req_cyc = 0;
            mem_ack_i = rnd_mem && $urandom_range(0, 7) == 0;
            mem_rdata_i = $urandom;
        end
    endtask

    task automatic do_reset();
        if_req_i = 0; if_flush_i = 0; d_req_i = 0; d_we_i = 0; mem_ack_i = 0;
        rst = 1;
        #10;
        rst = 0;
        model_reset();
    endtask

    task automatic wait_valid(input bit d, input string tag);
        int n;
        n = 0;
        do begin tick(); n++; end while (!(d ? d_valid_o : if_valid_o) && n < 60);
        check(tag, d ? d_valid_o : if_valid_o, 1);
    endtask

    initial begin
        int n;
        do_reset();
        check("rst_mem_req", mem_req_o, 0);
        check("rst_valids", {if_valid_o, d_valid_o}, 0);
        check("rst_rdata", {if_rdata_o, d_rdata_o}, 0);
        check("rst_mem_bus", {mem_we_o, mem_be_o, mem_addr_o}, 0);

        // fetch only, one wait cycle
        mem[32'h10 >> 2] = 32'h0050_0093;
        wait_n = 1;
        if_req_i = 1; if_addr_i = 32'h10;
        tick();
        check("t1_addr", mem_addr_o, 32'h10);
        check("t1_be", mem_be_o, 4'hF);
        tick();
        check("t1_no_valid_c2", if_valid_o, 0);
        tick();
        check("t1_valid_c3", if_valid_o, 1);
        check("t1_rdata", if_rdata_o, 32'h0050_0093);
        check("t1_stall_c3", stall_F_o, 0);
        if_req_i = 0;
        tick();

        // simultaneous requests: data first
        do_reset();
        mem[32'h100 >> 2] = 32'hDEAD_BEEF;
        if_req_i = 1; if_addr_i = 32'h10;
        d_req_i = 1; d_we_i = 0; d_addr_i = 32'h100;
        n_if = 0;
        wait_valid(1, "t2_d_timeout");
        check("t2_d_rdata", d_rdata_o, 32'hDEAD_BEEF);
        check("t2_fetch_later", n_if, 0);
        d_req_i = 0;
        tick();
        check("t2_idle", mem_req_o, 0);
        tick();
        check("t2_fetch_grant", {mem_req_o, mem_addr_o}, {1'b1, 32'h10});
        wait_valid(0, "t2_if_timeout");
        if_req_i = 0;
        tick();

        // starvation: four data grants then one fetch, twice
        do_reset();
        if_req_i = 1; if_addr_i = 32'h10;
        d_req_i = 1; d_we_i = 0; d_addr_i = 32'h100;
        n_if = 0; n_d = 0;
        wait_valid(0, "t3_if1_timeout");
        check("t3_d_before_if1", n_d, LIM);
        n_d = 0;
        wait_valid(0, "t3_if2_timeout");
        check("t3_d_before_if2", n_d, LIM);
        if_req_i = 0; d_req_i = 0;
        tick();

        // flush mid-fetch
        do_reset();
        wait_n = 1;
        if_req_i = 1; if_addr_i = 32'h10;
        wait_valid(0, "t4_pre_timeout");
        mem[32'h20 >> 2] = 32'h1111_2222;
        wait_n = 3;
        if_addr_i = 32'h20;
        tick();
        tick();
        check("t4_grant", {mem_req_o, mem_addr_o}, {1'b1, 32'h20});
        if_flush_i = 1; if_req_i = 0;
        tick();
        if_flush_i = 0;
        n_if = 0;
        for (int i = 0; i < 3; i++) tick();
        check("t4_ack_seen", s_ack, 1);
        check("t4_no_valid", if_valid_o, 0);
        check("t4_idle", mem_req_o, 0);
        if_req_i = 1; if_addr_i = 32'h30;
        tick();
        check("t4_regrant", {mem_req_o, mem_addr_o}, {1'b1, 32'h30});
        check("t4_rdata_kept", if_rdata_o, 32'h0050_0093);
        check("t4_no_pulse", n_if, 0);
        if_req_i = 0;
        wait_valid(0, "t4_post_timeout");
        tick();

        // store with wait states
        do_reset();
        wait_n = 1;
        mem[32'h200 >> 2] = 32'hAAAA_AAAA;
        d_req_i = 1; d_we_i = 0; d_addr_i = 32'h100;
        wait_valid(1, "t5_load_timeout");
        wait_n = 3;
        d_we_i = 1; d_addr_i = 32'h200; d_wdata_i = 32'h1234_5678; d_be_i = 4'b0011;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t5_bus", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o[23:0], mem_be_o},
                  {1'b1, 1'b1, 32'h200, 24'h345678, 4'b0011});
            tick();
        end
        check("t5_d_valid", d_valid_o, 1);
        check("t5_rdata_kept", d_rdata_o, 32'hDEAD_BEEF);
        check("t5_mem_merge", rd(32'h200), 32'hAAAA_5678);
        d_req_i = 0; d_we_i = 0;
        tick();

        // async reset in D_BUSY
        do_reset();
        wait_n = 5;
        d_req_i = 1; d_addr_i = 32'h100;
        tick();
        tick();
        check("t6_busy", mem_req_o, 1);
        rst = 1;
        #2;
        check("t6_req_drop", mem_req_o, 0);
        check("t6_valid_drop", {if_valid_o, d_valid_o}, 0);
        d_req_i = 0; mem_ack_i = 0;
        #10;
        rst = 0;
        model_reset();
        wait_n = 1;
        if_req_i = 1; if_addr_i = 32'h10;
        n = 0;
        do begin tick(); n++; end while (!if_valid_o && n < 20);
        check("t6_latency", n, 3);
        if_req_i = 0;
        tick();

        // randomized traffic with random memory latency and stray acks
        do_reset();
        rnd_mem = 1;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (if_valid_o || (if_flush_i && if_req_i)) begin
                if_req_i = $urandom_range(0, 3) != 0;
                if_addr_i = {26'h0, 4'($urandom), 2'b00};
            end else if (!if_req_i && $urandom_range(0, 2) == 0) begin
                if_req_i = 1;
                if_addr_i = {26'h0, 4'($urandom), 2'b00};
            end
            if_flush_i = $urandom_range(0, 9) == 0;
            if (d_valid_o || (!d_req_i && $urandom_range(0, 2) == 0)) begin
                d_req_i = d_valid_o ? $urandom_range(0, 2) != 0 : 1'b1;
                d_we_i = $urandom_range(0, 1) == 1;
                d_addr_i = {26'h0, 4'($urandom), 2'b00};
                d_wdata_i = $urandom;
                d_be_i = 4'($urandom);
            end
        end
        if_req_i = 0; d_req_i = 0; if_flush_i = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
